scoreboard_regfile: RTL



---
 rtl/scoreboard_regfile.sv | 100 ++++++++++
 1 files changed

// File: rtl/scoreboard_regfile.sv
// scoreboard_regfile: multi-port register file with per-entry busy bits, LVT-based multi-write and self-clearing init.
module scoreboard_regfile #(
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 32,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int HARDWIRE_ZERO   = 1,
  parameter int BYPASS          = 1,
  localparam int AddrWidth      = $clog2(DEPTH)
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_stall,
  input  logic [NUM_WRITE_PORTS-1:0]            i_write_enable,
  input  logic [NUM_WRITE_PORTS*AddrWidth-1:0]  i_write_addr,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] i_write_data,
  input  logic                                  i_alloc_valid,
  input  logic [AddrWidth-1:0]                  i_alloc_addr,
  input  logic [NUM_READ_PORTS*AddrWidth-1:0]   i_read_addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  o_read_data,
  output logic [NUM_READ_PORTS-1:0]             o_read_busy,
  output logic                                  o_ready
);
  localparam int LvtWidth = NUM_WRITE_PORTS > 1 ? $clog2(NUM_WRITE_PORTS) : 1;
  typedef enum logic {INIT, RUN} state_t;
  state_t                state;
  logic [AddrWidth-1:0]  cnt;
  logic [DEPTH-1:0]      busy;
  logic [LvtWidth-1:0]   lvt [DEPTH];
  logic [DATA_WIDTH-1:0] bank [NUM_WRITE_PORTS][NUM_READ_PORTS][DEPTH];
  logic [AddrWidth-1:0]  waddr [NUM_WRITE_PORTS];
  logic [DATA_WIDTH-1:0] wdata [NUM_WRITE_PORTS];
  logic [AddrWidth-1:0]  raddr [NUM_READ_PORTS];
  logic [DATA_WIDTH-1:0] rd [NUM_READ_PORTS];
  logic [NUM_READ_PORTS-1:0]  rb;
  logic [NUM_WRITE_PORTS-1:0] we;
  logic run, alloc;
  assign run     = state == RUN;
  assign o_ready = run;
  assign alloc   = run & i_alloc_valid & ~i_stall & (HARDWIRE_ZERO == 0 || i_alloc_addr != '0);
  for (genvar w = 0; w < NUM_WRITE_PORTS; w++) begin : g_wr
    assign waddr[w] = i_write_addr[w*AddrWidth +: AddrWidth];
    assign wdata[w] = i_write_data[w*DATA_WIDTH +: DATA_WIDTH];
    assign we[w]    = run & i_write_enable[w] & ~i_stall & (HARDWIRE_ZERO == 0 || waddr[w] != '0);
  end
  for (genvar r = 0; r < NUM_READ_PORTS; r++) begin : g_rd
    assign raddr[r] = i_read_addr[r*AddrWidth +: AddrWidth];
    assign o_read_data[r*DATA_WIDTH +: DATA_WIDTH] = rd[r];
    assign o_read_busy[r] = rb[r];
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= INIT;
      cnt   <= '0;
      busy  <= '0;
    end else if (state == INIT) begin
      cnt  <= cnt + 1'b1;
      busy <= '0;
      if (cnt == AddrWidth'(DEPTH - 1)) state <= RUN;
    end else begin
      for (int w = 0; w < NUM_WRITE_PORTS; w++)
        if (we[w]) busy[waddr[w]] <= 1'b0;
      if (alloc) busy[i_alloc_addr] <= 1'b1;
    end
  end
  // later ports override earlier ones, so the highest-index writer owns the entry
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) lvt[i] <= '0;
    end else if (!run) begin
      lvt[cnt] <= '0;
    end else begin
      for (int w = 0; w < NUM_WRITE_PORTS; w++)
        if (we[w]) lvt[waddr[w]] <= LvtWidth'(w);
    end
  end
  always_ff @(posedge i_clk) begin
    for (int w = 0; w < NUM_WRITE_PORTS; w++)
      for (int r = 0; r < NUM_READ_PORTS; r++)
        if (!run) bank[w][r][cnt] <= '0;
        else if (we[w]) bank[w][r][waddr[w]] <= wdata[w];
  end
  always_comb begin
    for (int r = 0; r < NUM_READ_PORTS; r++) begin
      rd[r] = bank[lvt[raddr[r]]][r][raddr[r]];
      rb[r] = busy[raddr[r]];
      if (BYPASS != 0)
        for (int w = 0; w < NUM_WRITE_PORTS; w++)
          if (we[w] && waddr[w] == raddr[r]) begin
            rd[r] = wdata[w];
            rb[r] = 1'b0;
          end
      if (HARDWIRE_ZERO != 0 && raddr[r] == '0) begin
        rd[r] = '0;
        rb[r] = 1'b0;
      end
      if (!run) rb[r] = 1'b0;
    end
  end
endmodule
